reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 101 ++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// Purpose: in-order retirement buffer; frees each superseded physical register at commit.
// Latency: completion seen at edge N retires at edge N+1; reg_commit/commit_addr valid the cycle after retirement.
// Backpressure: alloc_ready drops when all DEPTH entries are occupied or flush is asserted.
module reorder_buffer #(
  parameter int NUM_REG = 16,
  parameter int DEPTH   = 8,
  localparam int PW     = $clog2(NUM_REG),
  localparam int TW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          alloc_valid,
  input  logic          alloc_has_dest,
  input  logic [PW-1:0] alloc_old_preg,
  output logic          alloc_ready,
  output logic [TW-1:0] alloc_tag,
  input  logic          complete_valid,
  input  logic [TW-1:0] complete_tag,
  input  logic          flush,
  output logic          reg_commit,
  output logic [PW-1:0] commit_addr,
  output logic [TW:0]   count,
  output logic          empty
);

  // Per-entry state: valid/done are control bits, has_dest/old_preg are payload.
  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_done;
  logic [DEPTH-1:0] ent_has_dest;
  logic [PW-1:0]    ent_old_preg [DEPTH];

  // Pointers carry an extra wrap bit so full and empty can be told apart.
  logic [TW:0]   head;
  logic [TW:0]   tail;
  logic [TW-1:0] head_idx;
  logic [TW-1:0] tail_idx;
  logic          full;
  logic          retire;
  logic          alloc_fire;

  assign head_idx = head[TW-1:0];
  assign tail_idx = tail[TW-1:0];

  assign full        = (head_idx == tail_idx) && (head[TW] != tail[TW]);
  assign empty       = (head == tail);
  assign count       = tail - head;
  assign alloc_ready = !full && !flush;
  assign alloc_tag   = tail_idx;
  assign alloc_fire  = alloc_valid && alloc_ready;

  // Retirement looks only at registered done, so a completion needs one extra edge to retire.
  assign retire = ent_valid[head_idx] && ent_done[head_idx];

  // Control state: pointers, valid/done bits and the registered commit port.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      head        <= '0;
      tail        <= '0;
      ent_valid   <= '0;
      ent_done    <= '0;
      reg_commit  <= 1'b0;
      commit_addr <= '0;
    end else if (flush) begin
      // Flush discards everything, including a head that would otherwise retire now.
      head       <= '0;
      tail       <= '0;
      ent_valid  <= '0;
      ent_done   <= '0;
      reg_commit <= 1'b0;
    end else begin
      reg_commit <= 1'b0;
      // Completions on empty slots are dropped; re-completion just rewrites 1.
      if (complete_valid && ent_valid[complete_tag]) begin
        ent_done[complete_tag] <= 1'b1;
      end
      // Retire after the completion write so a same-edge completion of head cannot leave done stale.
      if (retire) begin
        ent_valid[head_idx] <= 1'b0;
        ent_done[head_idx]  <= 1'b0;
        head                <= head + 1'b1;
        reg_commit          <= ent_has_dest[head_idx];
        commit_addr         <= ent_old_preg[head_idx];
      end
      // Tail slot is never the head slot here: alloc requires !full, retire requires !empty.
      if (alloc_fire) begin
        ent_valid[tail_idx] <= 1'b1;
        ent_done[tail_idx]  <= 1'b0;
        tail                <= tail + 1'b1;
      end
    end
  end

  // Payload capture; contents are only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (n_rst && !flush && alloc_fire) begin
      ent_has_dest[tail_idx] <= alloc_has_dest;
      ent_old_preg[tail_idx] <= alloc_old_preg;
    end
  end

endmodule
